// File: rtl/ir_pkg.sv
// Shared constants, FSM encoding and frame-check helper for the IR command controller.
package ir_pkg;

    localparam logic [15:0] DEFAULT_CUSTOM_CODE = 16'h6B86;

    localparam logic [7:0]  KEY_SHIFT_ONE  = 8'h1E;
    localparam logic [7:0]  KEY_SHIFT_ZERO = 8'h1B;
    localparam logic [7:0]  KEY_INVERT     = 8'h1F;
    localparam logic [7:0]  KEY_MUTE       = 8'h0C;
    localparam logic [17:0] LED_ALL_ON     = 18'h3FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } ir_state_t;

    // A frame is good when the inverted-key byte matches and, if enforced, the custom code matches.
    function automatic logic frame_ok(input logic [31:0] frame,
                                      input logic        check_custom,
                                      input logic [15:0] custom_code);
        logic key_ok;
        logic code_ok;
        key_ok  = (frame[31:24] == ~frame[23:16]);
        code_ok = !check_custom || (frame[15:0] == custom_code);
        return key_ok && code_ok;
    endfunction

endpackage

// File: rtl/ir_cmd_fifo.sv
// Small synchronous command queue; a push while full is taken only if a pop happens in the same cycle.
module ir_cmd_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       iCLK,
    input  logic       iRST_n,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign empty     = (count_r == '0);
    assign full      = (count_r == FULL_CNT);
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    assign dout      = mem_r[rd_ptr_r];

    // Storage array carries no reset; only the pointers define validity.
    always_ff @(posedge iCLK) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= (wr_ptr_r == LAST_PTR) ? '0 : wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= (rd_ptr_r == LAST_PTR) ? '0 : rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW + 1)'(1);
                2'b01:   count_r <= count_r - (AW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ir_cmd_ctrl.sv
// IR remote command controller: validates frames, filters key repeats, queues keys and
// executes them on the LED register with a minimum spacing between updates.
module ir_cmd_ctrl
    import ir_pkg::*;
#(
    parameter logic [15:0] CUSTOM_CODE  = DEFAULT_CUSTOM_CODE,
    parameter bit          CHECK_CUSTOM = 1'b1,
    parameter int unsigned REPEAT_GAP   = 5000000,
    parameter int unsigned HOLD_CYCLES  = 2500000,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic        iDATA_READY,
    input  logic [31:0] iDATA,
    output logic [17:0] oLEDR,
    output logic [7:0]  oLEDG,
    output logic        oBUSY,
    output logic        oERR,
    output logic        oDROP
);
    localparam int unsigned REP_W  = $clog2(REPEAT_GAP + 1);
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [REP_W-1:0]  REP_MAX   = REP_W'(REPEAT_GAP);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    ir_state_t         state_r;
    ir_state_t         state_next_s;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [HOLD_W-1:0] hold_cnt_next_s;
    logic [REP_W-1:0]  rep_cnt_r;
    logic [17:0]       store_r;
    logic [7:0]        cmd_r;
    logic              apply_r;

    logic [7:0] key_s;
    logic       frame_ok_s;
    logic       valid_s;
    logic       repeat_s;
    logic       accept_s;
    logic       drop_s;
    logic       pop_s;
    logic       fifo_full_s;
    logic       fifo_empty_s;
    logic [7:0] fifo_dout_s;

    assign key_s      = iDATA[23:16];
    assign frame_ok_s = frame_ok(iDATA, CHECK_CUSTOM, CUSTOM_CODE);
    assign valid_s    = iDATA_READY && frame_ok_s;
    assign repeat_s   = (key_s == oLEDG) && (rep_cnt_r < REP_MAX);
    assign accept_s   = valid_s && !repeat_s;
    assign drop_s     = accept_s && fifo_full_s && !pop_s;
    assign oBUSY      = (state_r != ST_IDLE) || !fifo_empty_s;

    ir_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .iCLK   (iCLK),
        .iRST_n (iRST_n),
        .push   (accept_s),
        .din    (key_s),
        .pop    (pop_s),
        .dout   (fifo_dout_s),
        .full   (fifo_full_s),
        .empty  (fifo_empty_s)
    );

    // Frame intake: error/drop pulses, repeat timer and last accepted key.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oLEDG     <= 8'h00;
            rep_cnt_r <= REP_MAX;
            oERR      <= 1'b0;
            oDROP     <= 1'b0;
        end else begin
            oERR  <= iDATA_READY && !frame_ok_s;
            oDROP <= drop_s;
            if (valid_s) begin
                rep_cnt_r <= '0;
            end else if (rep_cnt_r < REP_MAX) begin
                rep_cnt_r <= rep_cnt_r + REP_W'(1);
            end
            if (accept_s) begin
                oLEDG <= key_s;
            end
        end
    end

    // FSM state and hold-counter registers.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_r    <= ST_IDLE;
            hold_cnt_r <= '0;
        end else begin
            state_r    <= state_next_s;
            hold_cnt_r <= hold_cnt_next_s;
        end
    end

    // Next-state logic; EXEC pops exactly one entry per pass.
    always_comb begin
        state_next_s    = state_r;
        hold_cnt_next_s = hold_cnt_r;
        pop_s           = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    state_next_s = ST_EXEC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                pop_s           = !fifo_empty_s;
                state_next_s    = ST_HOLD;
                hold_cnt_next_s = '0;
            end
            ST_HOLD: begin
                if (hold_cnt_r == HOLD_LAST) begin
                    state_next_s    = ST_IDLE;
                    hold_cnt_next_s = '0;
                end else begin
                    hold_cnt_next_s = hold_cnt_r + HOLD_W'(1);
                end
            end
            default: begin
                state_next_s    = ST_IDLE;
                hold_cnt_next_s = '0;
            end
        endcase
    end

    // The popped key is registered first so the LED update lands one edge after the pop.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            apply_r <= 1'b0;
            cmd_r   <= 8'h00;
        end else begin
            apply_r <= pop_s;
            if (pop_s) begin
                cmd_r <= fifo_dout_s;
            end
        end
    end

    // Key execution on the LED pattern and mute store.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oLEDR   <= 18'h00000;
            store_r <= 18'h00000;
        end else if (apply_r) begin
            case (cmd_r)
                KEY_SHIFT_ONE:  oLEDR <= {oLEDR[16:0], 1'b1};
                KEY_SHIFT_ZERO: oLEDR <= {oLEDR[16:0], 1'b0};
                KEY_INVERT:     oLEDR <= ~oLEDR;
                KEY_MUTE: begin
                    if (oLEDR != 18'h00000) begin
                        store_r <= oLEDR;
                        oLEDR   <= 18'h00000;
                    end else begin
                        oLEDR <= store_r;
                    end
                end
                default:        oLEDR <= LED_ALL_ON;
            endcase
        end
    end

endmodule

// File: tb/tb_ir_cmd_ctrl.sv
// Self-checking bench for ir_cmd_ctrl: directed scenarios plus random frames against a
// queue-and-timing reference model.
module tb_ir_cmd_ctrl;
    localparam int HOLD  = 4;
    localparam int GAP   = 20;
    localparam int DEPTH = 4;

    logic        iCLK        = 1'b0;
    logic        iRST_n      = 1'b0;
    logic        iDATA_READY = 1'b0;
    logic [31:0] iDATA       = 32'h0;
    logic [17:0] oLEDR;
    logic [7:0]  oLEDG;
    logic        oBUSY;
    logic        oERR;
    logic        oDROP;

    ir_cmd_ctrl #(
        .CUSTOM_CODE  (16'h6B86),
        .CHECK_CUSTOM (1'b1),
        .REPEAT_GAP   (GAP),
        .HOLD_CYCLES  (HOLD),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .iCLK        (iCLK),
        .iRST_n      (iRST_n),
        .iDATA_READY (iDATA_READY),
        .iDATA       (iDATA),
        .oLEDR       (oLEDR),
        .oLEDG       (oLEDG),
        .oBUSY       (oBUSY),
        .oERR        (oERR),
        .oDROP       (oDROP)
    );

    always #5 iCLK = ~iCLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: keys wait in a queue; an execution may start two edges after a key
    // arrives and no earlier than HOLD+2 edges after the previous one, landing one edge later.
    int          edge_n = 0;
    logic [17:0] m_led, m_store;
    logic [7:0]  m_ledg;
    logic [7:0]  q_key[$];
    int          q_time[$];
    bit          pend_v;
    logic [7:0]  pend_key;
    int          last_valid, last_pop, next_pop_ok;
    bit          have_valid, have_pop;
    logic        m_err, m_drop, m_busy;
    int          drop_seen = 0, drop_exp = 0;
    bit          spacing_on = 1'b0;
    int          last_change = 0;
    logic [17:0] prev_led = 18'h0;

    task automatic model_reset();
        m_led = 18'h0; m_store = 18'h0; m_ledg = 8'h00;
        q_key.delete(); q_time.delete();
        pend_v = 1'b0; pend_key = 8'h00;
        have_valid = 1'b0; have_pop = 1'b0;
        last_valid = 0; last_pop = 0; next_pop_ok = 0;
        m_err = 1'b0; m_drop = 1'b0; m_busy = 1'b0;
    endtask

    task automatic apply(input logic [7:0] k);
        case (k)
            8'h1E:   m_led = {m_led[16:0], 1'b1};
            8'h1B:   m_led = {m_led[16:0], 1'b0};
            8'h1F:   m_led = ~m_led;
            8'h0C: begin
                if (m_led != 18'h0) begin
                    m_store = m_led;
                    m_led   = 18'h0;
                end else begin
                    m_led = m_store;
                end
            end
            default: m_led = 18'h3FFFF;
        endcase
    endtask

    task automatic model_edge();
        logic [7:0] key;
        bit ok;
        bit rep;
        m_err  = 1'b0;
        m_drop = 1'b0;
        if (pend_v) begin
            apply(pend_key);
            pend_v = 1'b0;
        end
        if (q_key.size() > 0 && q_time[0] <= edge_n - 2 && edge_n >= next_pop_ok) begin
            pend_key = q_key.pop_front();
            void'(q_time.pop_front());
            pend_v = 1'b1;
            have_pop = 1'b1;
            last_pop = edge_n;
            next_pop_ok = edge_n + HOLD + 2;
        end
        if (iDATA_READY) begin
            key = iDATA[23:16];
            ok  = (iDATA[31:24] == ~key) && (iDATA[15:0] == 16'h6B86);
            if (!ok) begin
                m_err = 1'b1;
            end else begin
                rep = have_valid && (key == m_ledg) && ((edge_n - 1 - last_valid) < GAP);
                have_valid = 1'b1;
                last_valid = edge_n;
                if (!rep) begin
                    m_ledg = key;
                    if (q_key.size() < DEPTH) begin
                        q_key.push_back(key);
                        q_time.push_back(edge_n);
                    end else begin
                        m_drop = 1'b1;
                        drop_exp++;
                    end
                end
            end
        end
        m_busy = (q_key.size() > 0) || (have_pop && edge_n <= last_pop + HOLD - 1);
    endtask

    task automatic step();
        @(posedge iCLK);
        edge_n++;
        model_edge();
        #1;
        check("oLEDR", oLEDR, m_led);
        check("oLEDG", oLEDG, m_ledg);
        check("oERR", oERR, m_err);
        check("oDROP", oDROP, m_drop);
        check("oBUSY", oBUSY, m_busy);
        if (oDROP === 1'b1) drop_seen++;
        if (oLEDR !== prev_led) begin
            if (spacing_on) check("led_update_spacing", (edge_n - last_change) >= HOLD, 1'b1);
            last_change = edge_n;
            prev_led = oLEDR;
        end
        iDATA_READY = 1'b0;
        iDATA = $urandom;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic send(input logic [31:0] f);
        iDATA_READY = 1'b1;
        iDATA = f;
        step();
    endtask

    task automatic do_reset();
        @(negedge iCLK);
        iRST_n = 1'b0;
        iDATA_READY = 1'b0;
        #1;
        model_reset();
        check("rst_oLEDR", oLEDR, 18'h0);
        check("rst_oLEDG", oLEDG, 8'h00);
        check("rst_oERR", oERR, 1'b0);
        check("rst_oDROP", oDROP, 1'b0);
        check("rst_oBUSY", oBUSY, 1'b0);
        repeat (2) @(posedge iCLK);
        @(negedge iCLK);
        iRST_n = 1'b1;
        prev_led = 18'h0;
        last_change = edge_n;
    endtask

    function automatic logic [31:0] mk(input logic [7:0] key);
        return {~key, key, 16'h6B86};
    endfunction

    logic [7:0]  burst_keys [6] = '{8'h1B, 8'h1E, 8'h1F, 8'h1B, 8'h42, 8'h1E};
    logic [7:0]  prev_key;
    logic [7:0]  rkey;
    logic [31:0] rf;

    initial begin
        // First frame: latency and oLEDG
        do_reset();
        send(32'hE11E6B86);
        check("ledg_first", oLEDG, 8'h1E);
        check("err_first", oERR, 1'b0);
        idle(2);
        check("led_before_latency", oLEDR, 18'h00000);
        idle(1);
        check("led_latency3", oLEDR, 18'h00001);
        idle(10);

        // Bad checksum and bad custom code
        send(32'h001E6B86);
        check("err_checksum", oERR, 1'b1);
        check("ledg_kept", oLEDG, 8'h1E);
        idle(1);
        check("err_one_cycle", oERR, 1'b0);
        check("led_kept", oLEDR, 18'h00001);
        send({~8'h1B, 8'h1B, 16'h1234});
        check("err_custom", oERR, 1'b1);
        idle(10);

        // Repeat suppression
        do_reset();
        send(mk(8'h1E));
        idle(9);
        send(mk(8'h1E));
        idle(24);
        send(mk(8'h1E));
        idle(8);
        check("repeat_led", oLEDR, 18'h00003);

        // Overflow burst while holding
        do_reset();
        idle(2);
        send(mk(8'h1E));
        idle(2);
        check("busy_in_hold", oBUSY, 1'b1);
        drop_seen = 0;
        drop_exp = 0;
        spacing_on = 1'b1;
        for (int i = 0; i < 6; i++) send(mk(burst_keys[i]));
        idle(50);
        spacing_on = 1'b0;
        check("drop_count", drop_seen, drop_exp);
        check("burst_led", oLEDR, 18'h3FFE9);

        // Mute / unmute / invert
        do_reset();
        send(mk(8'h1E)); idle(30);
        send(mk(8'h1B)); idle(30);
        send(mk(8'h1E)); idle(30);
        check("led_pre_mute", oLEDR, 18'h00005);
        send(mk(8'h0C)); idle(30);
        check("led_muted", oLEDR, 18'h00000);
        send(mk(8'h0C)); idle(30);
        check("led_unmuted", oLEDR, 18'h00005);
        send(mk(8'h1F)); idle(30);
        check("led_inverted", oLEDR, 18'h3FFFA);

        // Reset during HOLD with two entries queued
        do_reset();
        send(mk(8'h1E));
        send(mk(8'h1B));
        send(mk(8'h1F));
        idle(2);
        check("busy_before_rst", oBUSY, 1'b1);
        do_reset();
        idle(20);
        check("led_after_rst", oLEDR, 18'h00000);
        check("busy_after_rst", oBUSY, 1'b0);

        // Random frames
        prev_key = 8'h1E;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 5))
                0:       rkey = 8'h1E;
                1:       rkey = 8'h1B;
                2:       rkey = 8'h1F;
                3:       rkey = 8'h0C;
                4:       rkey = prev_key;
                default: rkey = 8'($urandom);
            endcase
            rf = mk(rkey);
            case ($urandom_range(0, 9))
                0:       rf[31:24] = rf[31:24] ^ 8'h01;
                1:       rf[15:0]  = 16'h6B87;
                default: rf = rf;
            endcase
            prev_key = rkey;
            send(rf);
            idle($urandom_range(0, 25));
            if (i == 200) do_reset();
        end
        idle(40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ir_cmd_ctrl.md
IR_CMD_CTRL -- requirements
Module: ir_cmd_ctrl

Interface
REQ-001 SHALL have parameter CUSTOM_CODE, default 16'h6B86: required value of frame bits [15:0].
REQ-002 SHALL have parameter CHECK_CUSTOM, default 1: 1 = enforce CUSTOM_CODE; 0 = ignore bits [15:0].
REQ-003 SHALL have parameter REPEAT_GAP, default 5000000: cycles (100 ms at 50 MHz) within which a repeated identical key is suppressed.
REQ-004 SHALL have parameter HOLD_CYCLES, default 2500000: minimum cycles between consecutive LED updates.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4: command queue entries (power of two).
REQ-006 iCLK  in  1  system clock, 50 MHz.
REQ-007 iRST_n  in  1  reset; asynchronous, active-low.
REQ-008 iDATA_READY  in  1  single-cycle pulse from the IR receiver, synchronous to iCLK.
REQ-009 iDATA  in  32  decoded frame: [15:0] custom code, [23:16] key, [31:24] inverted key; valid when iDATA_READY=1.
REQ-010 oLEDR  out  18  LED pattern register.
REQ-011 oLEDG  out  8  last accepted key code.
REQ-012 oBUSY  out  1  high while the FSM is not IDLE or the FIFO is non-empty.
REQ-013 oERR  out  1  one-cycle pulse on a rejected frame (checksum or custom-code mismatch).
REQ-014 oDROP  out  1  one-cycle pulse when an accepted command is lost to FIFO overflow.

Function
REQ-015 SHALL sample iDATA only on the rising edge where iDATA_READY=1; at all other times iDATA is ignored.
REQ-016 SHALL reject the frame with an oERR pulse on the next cycle if [31:24] != ~[23:16], or if CHECK_CUSTOM=1 and [15:0] != CUSTOM_CODE.
REQ-017 SHALL run a repeat counter that restarts at 0 on every valid frame and saturates at REPEAT_GAP.
REQ-018 SHALL treat a valid frame as a repeat, discarding it silently and still restarting the counter, when:
- its key equals the last accepted key, and
- the counter is below REPEAT_GAP.
REQ-019 SHALL push each accepted key into the FIFO on the sampling edge and load oLEDG with it on the same edge.
REQ-020 SHALL accept a push while the FIFO is full only if a pop occurs in the same cycle; otherwise the key is dropped, oDROP pulses, and oLEDG still updates.
REQ-021 SHALL implement FSM IDLE -> EXEC -> HOLD -> IDLE:
- IDLE -> EXEC when the FIFO is non-empty.
- EXEC pops one entry, updates oLEDR, then goes to HOLD.
- HOLD counts HOLD_CYCLES cycles, then returns to IDLE.
REQ-022 SHALL give a latency of 3 rising edges from the edge sampling iDATA_READY to the oLEDR update, with the FSM idle and the FIFO empty.
REQ-023 SHALL execute each key code as follows:
- 8'h1E: oLEDR <= {oLEDR[16:0],1'b1}.
- 8'h1B: oLEDR <= {oLEDR[16:0],1'b0}.
- 8'h1F: oLEDR <= ~oLEDR.
- 8'h0C (mute): if oLEDR != 0, store <= oLEDR and oLEDR <= 0; else oLEDR <= store.
- Any other code: oLEDR <= 18'h3FFFF.
REQ-024 SHALL discard bits shifted out of oLEDR[17]; there is no wrap-around.
REQ-025 SHALL apply a mute with store=0 and oLEDR=0 as a no-op that leaves oLEDR at 0.
REQ-026 SHALL continue to accept, filter and queue frames during HOLD; only execution is spaced.
REQ-027 SHALL stall the FIFO and the repeat counter only during reset.

Reset
REQ-028 SHALL, while iRST_n=0, immediately force:
- oLEDR=0, store=0, oLEDG=0, last key=0.
- Repeat counter=REPEAT_GAP, so the first frame after reset is never a repeat.
- FIFO empty, FSM IDLE, HOLD counter 0.
- oERR=oDROP=oBUSY=0.
REQ-029 SHALL, on reset asserted mid-EXEC or mid-HOLD, discard queued commands and apply no partial update.

Structure
REQ-030 SHALL place the key-code constants (1E, 1B, 1F, 0C), the FSM state encoding and the default CUSTOM_CODE in the shared package ir_pkg.
REQ-031 SHALL implement the command queue as sub-module ir_cmd_fifo (8-bit data, FIFO_DEPTH entries, push/pop/full/empty, same-cycle push+pop on full allowed).
REQ-032 SHALL be simulable with HOLD_CYCLES=4 and REPEAT_GAP=20 overrides.

Verification (HOLD_CYCLES=4, REPEAT_GAP=20)
REQ-033 Reset, then frame 32'hE11E6B86 -> oLEDG=8'h1E; oLEDR=18'h00001 exactly 3 edges after the sampling edge; oERR=0.
REQ-034 Frame 32'h001E6B86 (bad checksum) -> oERR pulses one cycle; oLEDR and oLEDG unchanged.
REQ-035 Frame with key 1E, then the same frame 10 cycles later -> second frame suppressed. A third identical frame 25 cycles after the second -> accepted; oLEDR goes 00001 -> 00003.
REQ-036 Six distinct accepted keys in consecutive-spaced frames with the FSM in HOLD -> exactly the overflow keys raise oDROP. Queued keys execute in order, spaced ≥4 cycles apart.
REQ-037 oLEDR=18'h00005, then mute -> oLEDR=0. Then mute again -> oLEDR=18'h00005. Then 8'h1F -> 18'h3FFFA.
REQ-038 Assert iRST_n=0 during HOLD with 2 entries queued -> all outputs at reset values; no further oLEDR changes after release.
